// File: rtl/minas_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minas_pkg
//  Purpose  : Shared board geometry, cell codes, board type and FSM states
//             for the minesweeper datapath.
//  Revision : 1.0 - initial release
// ============================================================================
package minas_pkg;

  localparam int         ROWS      = 8;
  localparam int         COLS      = 8;
  localparam logic [3:0] BOMB_CODE = 4'hF;

  // Board type shared with the adjacent-bomb counting stage, indexed [row][col]
  typedef logic [7:0][7:0][3:0] matriz_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    DONE  = 2'd3
  } estado_t;

  // Clamp a bomb request to the configured limit
  function automatic logic [5:0] satBombs(input logic [5:0] req, input logic [5:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr8
//  Purpose  : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 (period 255).
//             A zero seed would lock the register, so it is replaced by 01.
//  Revision : 1.0 - initial release
// ============================================================================
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] r_state;
  logic [7:0] w_seedEff;
  logic       w_feedback;

  assign w_seedEff  = (seed == 8'h00) ? 8'h01 : seed;
  assign w_feedback = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];
  assign q          = r_state;

  // Free-running shift every cycle; reload the (sanitised) seed on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= w_seedEff;
    end else begin
      r_state <= {r_state[6:0], w_feedback};
    end
  end

endmodule
`default_nettype wire

// File: rtl/colocar_bombas.sv
`default_nettype none
// ============================================================================
//  Module   : colocar_bombas
//  Purpose  : Clears the 8x8 board and places a requested number of distinct
//             bombs at pseudo-random cells, never on the protected safe cell.
//             Bomb cells hold BOMB_CODE, all others 0; the board is held
//             until the next accepted start or reset.
//  Revision : 1.0 - initial release
// ============================================================================
module colocar_bombas
  import minas_pkg::*;
#(
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         MAX_BOMBS = 63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] num_bombs,
  input  logic [2:0] safe_row,
  input  logic [2:0] safe_col,
  output matriz_t    matrizBombas,
  output logic [5:0] bomb_count,
  output logic       busy,
  output logic       done
);

  localparam int         c_rowBits  = $clog2(ROWS);
  localparam int         c_colBits  = $clog2(COLS);
  localparam logic [5:0] c_maxBombs = (MAX_BOMBS > 63) ? 6'd63 : MAX_BOMBS[5:0];

  estado_t              r_state;
  estado_t              w_nextState;
  logic [5:0]           r_target;
  logic [2:0]           r_safeRow;
  logic [2:0]           r_safeCol;
  matriz_t              r_board;
  logic [5:0]           r_count;
  logic [7:0]           w_lfsr;
  logic [c_rowBits-1:0] w_candRow;
  logic [c_colBits-1:0] w_candCol;
  logic                 w_candFree;
  logic                 w_accept;
  logic                 w_clear;
  logic                 w_place;
  logic                 w_unusedLfsrHi;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (w_lfsr)
  );

  // Candidate cell comes from the low six LFSR bits; the top two are not used
  assign w_candRow      = w_lfsr[5:3];
  assign w_candCol      = w_lfsr[2:0];
  assign w_unusedLfsrHi = ^w_lfsr[7:6];
  assign w_candFree     = (r_board[w_candRow][w_candCol] == 4'h0) &&
                          !((w_candRow == r_safeRow) && (w_candCol == r_safeCol));

  assign matrizBombas = r_board;
  assign bomb_count   = r_count;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and per-state strobes for the datapath
  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_accept    = 1'b0;
    w_clear     = 1'b0;
    w_place     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = CLEAR;
        end
      end
      CLEAR: begin
        busy        = 1'b1;
        w_clear     = 1'b1;
        w_nextState = (r_target == 6'd0) ? DONE : PLACE;
      end
      PLACE: begin
        busy = 1'b1;
        if (w_candFree) begin
          w_place = 1'b1;
          if ((r_count + 6'd1) == r_target) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Request latches: captured only when a start is accepted in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_target  <= 6'd0;
      r_safeRow <= 3'd0;
      r_safeCol <= 3'd0;
    end else if (w_accept) begin
      r_target  <= satBombs(num_bombs, c_maxBombs);
      r_safeRow <= safe_row;
      r_safeCol <= safe_col;
    end
  end

  // Board and counter: wiped in CLEAR, one bomb written per placing cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_board <= '0;
      r_count <= 6'd0;
    end else if (w_clear) begin
      r_board <= '0;
      r_count <= 6'd0;
    end else if (w_place) begin
      r_board[w_candRow][w_candCol] <= BOMB_CODE;
      r_count                       <= r_count + 6'd1;
    end
  end

endmodule
`default_nettype wire
